color_mapper_fx: RTL and testbench
==================================

// Module: color_mapper_fx
// PURPOSE
//  Pipelined, parametrised successor to the combinational screen colour mapper.
//  Maps each (DrawX,DrawY) pixel to RGB using the active screen, with NUM_PICKS circular pick sprites.
//  Adds a frame-locked fade-out/swap/fade-in transition between screens.
//  Sits between the VGA controller and the DAC output registers.
// PARAMETERS
//  COORD_W    10  width of DrawX/DrawY/PickX/PickY (must be >= 7)
//  NUM_PICKS  4   number of pick sprites tested per pixel
//  PICK_R     5   pick radius in pixels; hit when dx*dx + dy*dy <= PICK_R*PICK_R
//  FADE_W     4   fade level fraction width; level range is 0..2**FADE_W
//  FADE_STEP  1   level change per frame_start pulse during a fade
// PORTS
//  Clk               in   1                    system clock
//  Reset_n           in   1                    asynchronous, active-low reset
//  pix_valid_in      in   1                    DrawX/DrawY qualify a pixel this cycle
//  DrawX, DrawY      in   COORD_W              pixel coordinate
//  PickX, PickY      in   NUM_PICKS*COORD_W    packed pick centres; index 0 in the LSBs
//  frame_start       in   1                    one-cycle pulse per frame (vsync edge)
//  ScreenReq         in   3                    requested screen
//  ScreenReqValid    in   1                    request strobe
//  Busy              out  1                    transition in progress; requests are dropped
//  ActiveScreen      out  3                    screen currently rendered
//  pix_valid_out     out  1                    RGB valid; pix_valid_in delayed 2 cycles
//  Red, Green, Blue  out  8 each               pixel colour
// BEHAVIOUR
//  Clocking and reset
//   - One clock; reset is asynchronous and active-low.
//   - Reset values: all outputs 0, ActiveScreen=0, Busy=0, FSM=IDLE, level=2**FADE_W.
//   - Reset mid-fade aborts the transition; the pipeline valid bits clear.
//  Pipeline (latency 2, throughput 1 pixel/clk, no stall)
//   - S1 registers per-pick hit bits, DrawX/DrawY and valid.
//     dx, dy: signed COORD_W+1; squares: 2*COORD_W+2 bits; sum: one more bit; no overflow.
//   - S2 registers the selected colour after fade scaling.
//   - When a pixel is not valid, its S2 RGB is 0.
//  Pick hit: the lowest-index hitting pick wins its PICK_COLOR[i]; pick_on = OR of all hits.
//  Screen base colour (8-bit modular arithmetic; gx/gy = DrawX/DrawY[COORD_W-1 -: 7])
//   - 0: R=0x7F-gx, G=0, B=0
//   - 1: pick_on ? PICK_COLOR[winner] : R=0x70, G=0, B=0
//   - 2: pick_on ? PICK_COLOR[winner] : R=0x11-gy (wraps), G=0, B=0
//   - 7: R=0, G=0x7F-gx, B=0
//   - others: R=0, G=0, B=0x77
//  Fade: each channel = (base*level) >> FADE_W. Full level passes through unchanged; level 0 gives black.
//  FSM IDLE -> FADE_OUT -> SWAP -> FADE_IN -> IDLE
//   - IDLE: ScreenReqValid with ScreenReq != ActiveScreen latches the target, sets Busy next cycle, enters FADE_OUT.
//     A request equal to ActiveScreen is ignored.
//   - FADE_OUT: each frame_start sets level = max(level-FADE_STEP, 0). At level 0, go to SWAP.
//   - SWAP: ActiveScreen <= target for one cycle, then FADE_IN.
//   - FADE_IN: each frame_start sets level = min(level+FADE_STEP, 2**FADE_W). At full level, go to IDLE; Busy clears that cycle.
//   - Requests while Busy are dropped, not queued.
//   - frame_start in the same cycle a request is accepted is not counted.
//   - A level change takes effect on the next S2 pixel. No mid-line tearing constraint is imposed.
// STRUCTURE
//  color_mapper_pkg: screen_e enum (SCR_TITLE=0, SCR_PLAY=1, SCR_PLAY2=2, SCR_WIN=7), rgb_t struct,
//    fade_state_e enum, PICK_COLOR[8] table (0: 00/7F/00, then distinct colours), default screen colours.
//  pick_hit_detect: one instance per pick via generate; combinational dx/dy/compare feeding S1.
//  Top level: S1/S2 registers, priority select, fade multiply, FSM.
// TESTING
//  1 Screen 0, DrawX=0x000 then 0x3F8, valid -> 2 cycles later Red=0x7F then 0x00; G=B=0.
//  2 Screen 1, Pick0=(100,100), pixel (103,104) -> G=0x7F (dist^2=25). Pixel (104,104) -> R=0x70.
//  3 Picks 0 and 2 both hit one pixel -> PICK_COLOR[0]. Only pick 2 hits -> PICK_COLOR[2].
//  4 Screen 2, DrawY=0x0A0 (gy=0x14) -> Red=0xFD (wrap). Screen 5 -> B=0x77.
//  5 ScreenReq=7 from 0 with FADE_W=4, STEP=1 -> Busy; 16 frames down to black; ActiveScreen=7;
//    16 frames up; Busy=0. A request at frame 5 is dropped.
//  6 Reset_n low mid-FADE_IN -> outputs 0 immediately, ActiveScreen=0, level full after release.

Source files
------------

// File: rtl/color_mapper_pkg.sv
// Shared types and colour tables for the pipelined screen colour mapper.
// Screen encodings, fade FSM states, and the pick sprite palette.
package color_mapper_pkg;

  typedef enum logic [2:0] {
    SCR_TITLE = 3'd0,
    SCR_PLAY  = 3'd1,
    SCR_PLAY2 = 3'd2,
    SCR_WIN   = 3'd7
  } screen_e;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FADE_OUT,
    FS_SWAP,
    FS_FADE_IN
  } fade_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t PICK_COLOR [8] = '{
    '{8'h00, 8'h7F, 8'h00},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'h80, 8'h80, 8'h80}
  };

  localparam rgb_t PLAY_BG  = '{8'h70, 8'h00, 8'h00};
  localparam rgb_t OTHER_BG = '{8'h00, 8'h00, 8'h77};

endpackage

// File: rtl/color_mapper_fx_pick_hit_detect.sv
// Combinational circular hit test of one pixel against one pick centre.
module pick_hit_detect #(
  parameter int COORD_W = 10,
  parameter int PICK_R  = 5
) (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] pick_x,
  input  logic [COORD_W-1:0] pick_y,
  output logic               hit
);

  localparam int SQ_W = 2*COORD_W + 2;
  localparam logic [SQ_W:0] R_SQ = (SQ_W+1)'(PICK_R*PICK_R);

  logic signed [COORD_W:0] dx, dy;
  logic signed [SQ_W-1:0]  dx_w, dy_w;
  logic        [SQ_W-1:0]  dx_sq, dy_sq;
  logic        [SQ_W:0]    dist_sq;

  assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, pick_x});
  assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, pick_y});
  assign dx_w = {{(COORD_W+1){dx[COORD_W]}}, dx};
  assign dy_w = {{(COORD_W+1){dy[COORD_W]}}, dy};
  assign dx_sq = dx_w * dx_w;
  assign dy_sq = dy_w * dy_w;
  assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
  assign hit = (dist_sq <= R_SQ);

endmodule

// File: rtl/color_mapper_fx.sv
// Two-stage pixel colour mapper with pick sprites and a frame-locked
// fade-out / screen swap / fade-in transition.
module color_mapper_fx
  import color_mapper_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int NUM_PICKS = 4,
  parameter int PICK_R    = 5,
  parameter int FADE_W    = 4,
  parameter int FADE_STEP = 1
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           pix_valid_in,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_PICKS*COORD_W-1:0]   PickX,
  input  logic [NUM_PICKS*COORD_W-1:0]   PickY,
  input  logic                           frame_start,
  input  logic [2:0]                     ScreenReq,
  input  logic                           ScreenReqValid,
  output logic                           Busy,
  output logic [2:0]                     ActiveScreen,
  output logic                           pix_valid_out,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue
);

  localparam logic [FADE_W:0] LEVEL_FULL = (FADE_W+1)'(2**FADE_W);
  localparam logic [FADE_W:0] STEP       = (FADE_W+1)'(FADE_STEP);

  fade_state_e state, state_next;
  logic [FADE_W:0] level, level_next;
  logic [2:0] target, target_next, active, active_next;

  logic [NUM_PICKS-1:0] hit_c, s1_hit;
  logic [6:0] s1_gx, s1_gy;
  logic s1_valid;
  rgb_t pick_col, base;
  logic found;

  for (genvar i = 0; i < NUM_PICKS; i++) begin : g_pick
    pick_hit_detect #(.COORD_W(COORD_W), .PICK_R(PICK_R)) u_hit (
      .draw_x(DrawX),
      .draw_y(DrawY),
      .pick_x(PickX[i*COORD_W +: COORD_W]),
      .pick_y(PickY[i*COORD_W +: COORD_W]),
      .hit   (hit_c[i])
    );
  end

  // Only the coarse 7-bit grid coordinate is consumed downstream.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_gx    <= '0;
      s1_gy    <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_hit   <= hit_c;
      s1_gx    <= DrawX[COORD_W-1 -: 7];
      s1_gy    <= DrawY[COORD_W-1 -: 7];
    end
  end

  always_comb begin
    pick_col = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_PICKS; i++) begin
      if (s1_hit[i] && !found) begin
        found    = 1'b1;
        pick_col = PICK_COLOR[i[2:0]];
      end
    end
    base = '0;
    case (active)
      SCR_TITLE: base.r = 8'h7F - {1'b0, s1_gx};
      SCR_PLAY:  base = found ? pick_col : PLAY_BG;
      SCR_PLAY2: begin
        if (found) base = pick_col;
        else       base.r = 8'h11 - {1'b0, s1_gy};
      end
      SCR_WIN:   base.g = 8'h7F - {1'b0, s1_gx};
      default:   base = OTHER_BG;
    endcase
  end

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [FADE_W:0] lv);
    logic [8+FADE_W:0] prod;
    prod = {{(FADE_W+1){1'b0}}, c} * {8'b0, lv};
    return 8'(prod >> FADE_W);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      Red           <= '0;
      Green         <= '0;
      Blue          <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      Red           <= s1_valid ? fade_ch(base.r, level) : '0;
      Green         <= s1_valid ? fade_ch(base.g, level) : '0;
      Blue          <= s1_valid ? fade_ch(base.b, level) : '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= FS_IDLE;
      level  <= LEVEL_FULL;
      target <= '0;
      active <= '0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      target <= target_next;
      active <= active_next;
    end
  end

  // IDLE never looks at frame_start, so a pulse coinciding with acceptance is not counted.
  always_comb begin
    state_next  = state;
    level_next  = level;
    target_next = target;
    active_next = active;
    case (state)
      FS_IDLE: begin
        if (ScreenReqValid && (ScreenReq != active)) begin
          target_next = ScreenReq;
          state_next  = FS_FADE_OUT;
        end
      end
      FS_FADE_OUT: begin
        if (level == '0)
          state_next = FS_SWAP;
        else if (frame_start)
          level_next = (level > STEP) ? level - STEP : '0;
      end
      FS_SWAP: begin
        active_next = target;
        state_next  = FS_FADE_IN;
      end
      FS_FADE_IN: begin
        if (level == LEVEL_FULL)
          state_next = FS_IDLE;
        else if (frame_start)
          level_next = (({1'b0, level} + {1'b0, STEP}) >= {1'b0, LEVEL_FULL}) ?
                       LEVEL_FULL : level + STEP;
      end
      default: state_next = FS_IDLE;
    endcase
  end

  assign Busy         = (state != FS_IDLE);
  assign ActiveScreen = active;

endmodule

// File: tb/tb_color_mapper_fx.sv
// Directed self-checking bench for color_mapper_fx with default parameters.
module tb_color_mapper_fx;

  logic        Clk, Reset_n, pix_valid_in, frame_start, ScreenReqValid;
  logic [9:0]  DrawX, DrawY;
  logic [39:0] PickX, PickY;
  logic [2:0]  ScreenReq;
  logic        Busy, pix_valid_out;
  logic [2:0]  ActiveScreen;
  logic [7:0]  Red, Green, Blue;

  int n_cmp = 0;
  int n_err = 0;

  color_mapper_fx #(.COORD_W(10), .NUM_PICKS(4), .PICK_R(5), .FADE_W(4), .FADE_STEP(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .PickX(PickX), .PickY(PickY),
    .frame_start(frame_start), .ScreenReq(ScreenReq), .ScreenReqValid(ScreenReqValid),
    .Busy(Busy), .ActiveScreen(ActiveScreen), .pix_valid_out(pix_valid_out),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                       input string tag);
    DrawX = x;
    DrawY = y;
    pix_valid_in = 1'b1;
    tick();
    pix_valid_in = 1'b0;
    tick();
    check({tag, "_vld"}, pix_valid_out, 1);
    check({tag, "_r"}, Red, er);
    check({tag, "_g"}, Green, eg);
    check({tag, "_b"}, Blue, eb);
  endtask

  task automatic goto_screen(input logic [2:0] s);
    ScreenReq = s;
    ScreenReqValid = 1'b1;
    tick();
    ScreenReqValid = 1'b0;
    for (int i = 0; i < 100 && Busy; i++) frame();
    check("goto_busy", Busy, 0);
    check("goto_active", ActiveScreen, s);
  endtask

  initial begin
    Reset_n = 1'b0;
    pix_valid_in = 1'b0;
    frame_start = 1'b0;
    ScreenReqValid = 1'b0;
    ScreenReq = 3'd0;
    DrawX = '0;
    DrawY = '0;
    // pick0=(100,100), pick1=(900,900), pick2=(110,100), pick3=(900,900)
    PickX = {10'd900, 10'd110, 10'd900, 10'd100};
    PickY = {10'd900, 10'd100, 10'd900, 10'd100};
    tick();
    tick();
    check("rst_busy", Busy, 0);
    check("rst_active", ActiveScreen, 0);
    check("rst_vld", pix_valid_out, 0);
    check("rst_rgb", {Red, Green, Blue}, 0);
    Reset_n = 1'b1;
    tick();

    // Screen 0 gradient, including its far edge
    pixel(10'h000, 10'h000, 8'h7F, 8'h00, 8'h00, "scr0_x0");
    pixel(10'h3F8, 10'h000, 8'h00, 8'h00, 8'h00, "scr0_x3f8");
    DrawX = 10'h000;
    tick();
    tick();
    check("invalid_vld", pix_valid_out, 0);
    check("invalid_rgb", {Red, Green, Blue}, 0);

    // Request for the already active screen is ignored
    ScreenReq = 3'd0;
    ScreenReqValid = 1'b1;
    tick();
    ScreenReqValid = 1'b0;
    check("same_req_busy", Busy, 0);

    // Transition 0 -> 7; coincident frame_start must not count
    ScreenReq = 3'd7;
    ScreenReqValid = 1'b1;
    frame_start = 1'b1;
    tick();
    ScreenReqValid = 1'b0;
    frame_start = 1'b0;
    check("accept_busy", Busy, 1);
    pixel(10'h000, 10'h000, 8'h7F, 8'h00, 8'h00, "fade_full");
    repeat (5) frame();
    ScreenReq = 3'd1;
    ScreenReqValid = 1'b1;
    tick();
    ScreenReqValid = 1'b0;
    repeat (3) frame();
    // level 8: 0x7F*8>>4 = 0x3F
    pixel(10'h000, 10'h000, 8'h3F, 8'h00, 8'h00, "fade_l8");
    repeat (8) frame();
    check("black_busy", Busy, 1);
    pixel(10'h000, 10'h000, 8'h00, 8'h00, 8'h00, "fade_black");
    check("swap_active", ActiveScreen, 7);
    repeat (15) frame();
    check("fadein_busy", Busy, 1);
    frame();
    tick();
    check("done_busy", Busy, 0);
    check("dropped_req", ActiveScreen, 7);
    pixel(10'h000, 10'h000, 8'h00, 8'h7F, 8'h00, "scr7");

    // Screen 1 picks
    goto_screen(3'd1);
    pixel(10'd103, 10'd104, 8'h00, 8'h7F, 8'h00, "pick_r25");
    pixel(10'd104, 10'd104, 8'h70, 8'h00, 8'h00, "pick_miss");
    pixel(10'd105, 10'd100, 8'h00, 8'h7F, 8'h00, "pick_both");
    pixel(10'd112, 10'd100, 8'h00, 8'h00, 8'hFF, "pick2_only");

    // Screen 2 wrap and pick; screen 5 default
    goto_screen(3'd2);
    pixel(10'd500, 10'h0A0, 8'hFD, 8'h00, 8'h00, "scr2_wrap");
    pixel(10'd103, 10'd104, 8'h00, 8'h7F, 8'h00, "scr2_pick");
    goto_screen(3'd5);
    pixel(10'd500, 10'h0A0, 8'h00, 8'h00, 8'h77, "scr5");

    // Reset during FADE_IN at level 3
    ScreenReq = 3'd7;
    ScreenReqValid = 1'b1;
    tick();
    ScreenReqValid = 1'b0;
    repeat (16) frame();
    tick();
    repeat (3) frame();
    DrawX = 10'h000;
    DrawY = 10'h000;
    pix_valid_in = 1'b1;
    tick();
    tick();
    // 0x7F*3>>4 = 0x17
    check("mid_in_g", Green, 8'h17);
    check("mid_in_busy", Busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_vld", pix_valid_out, 0);
    check("arst_rgb", {Red, Green, Blue}, 0);
    check("arst_busy", Busy, 0);
    check("arst_active", ActiveScreen, 0);
    pix_valid_in = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    pixel(10'h000, 10'h000, 8'h7F, 8'h00, 8'h00, "post_rst_full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
